// File: rtl/mem_pkg.sv
// Shared definitions for the scratch-RAM arbiter: default RAM geometry and
// requester identifiers.
package mem_pkg;

  localparam int unsigned DW = 4;  // RAM data width
  localparam int unsigned AW = 5;  // RAM address width (32 words)

  // Requester identifiers; also the index of each requester in grant vectors.
  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DBG = 1'b1;

endpackage : mem_pkg

// File: rtl/rr_arb2.sv
// Two-way round-robin grant logic with its priority pointer.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   req[1:0]   : request vector, bit i = requester i
//   gnt[1:0]   : one-hot (or zero) grant, combinational, forced 0 in reset
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic prio;  // requester preferred when both request

  // Grant: a lone requester always wins; on contention the pointer decides.
  always_comb begin
    gnt = 2'b00;
    if (rst_n) begin
      if (req == 2'b11) begin
        gnt[prio] = 1'b1;
      end else begin
        gnt = req;
      end
    end
  end

  // After any grant the loser of this cycle becomes preferred (prio <= ~winner).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio <= 1'b0;
    end else if (|gnt) begin
      prio <= gnt[0];
    end
  end

endmodule : rr_arb2

// File: rtl/mem_arbiter.sv
// Round-robin arbiter/sequencer in front of the 32xDW synchronous scratch RAM.
// Issues at most one RAM operation per cycle and routes read data (1-cycle
// latency) back to the requester that issued the read.
// Ports:
//   clk, rst_n               : clock, asynchronous active-low reset
//   req*/we*/addr*/wdata*    : requester commands (0 = CPU, 1 = debug/load)
//   gnt*                     : command accepted this cycle (combinational)
//   rvalid*/rdata*           : read return per requester
//   mem_read/mem_write       : RAM enables
//   mem_read_address         : RAM read address
//   mem_write_address        : RAM write address
//   mem_data_to_write        : RAM write data
//   mem_data_read            : RAM registered read data
module mem_arbiter #(
  parameter int unsigned DW = mem_pkg::DW,
  parameter int unsigned AW = mem_pkg::AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          mem_read,
  output logic          mem_write,
  output logic [AW-1:0] mem_read_address,
  output logic [AW-1:0] mem_write_address,
  output logic [DW-1:0] mem_data_to_write,
  input  logic [DW-1:0] mem_data_read
);

  logic [1:0]    gnt;
  logic          granted;
  logic          winner;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          pend_rd;
  logic          pend_id;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   ({req1, req0}),
    .gnt   (gnt)
  );

  assign gnt0    = gnt[0];
  assign gnt1    = gnt[1];
  assign granted = |gnt;
  assign winner  = gnt[1] ? mem_pkg::REQ_DBG : mem_pkg::REQ_CPU;

  // Command mux: the winner's command drives the RAM; idle cycles drive zeros.
  always_comb begin
    sel_we            = (winner == mem_pkg::REQ_DBG) ? we1    : we0;
    sel_addr          = (winner == mem_pkg::REQ_DBG) ? addr1  : addr0;
    sel_wdata         = (winner == mem_pkg::REQ_DBG) ? wdata1 : wdata0;
    mem_write         = granted & sel_we;
    mem_read          = granted & ~sel_we;
    mem_write_address = mem_write ? sel_addr  : AW'(0);
    mem_read_address  = mem_read  ? sel_addr  : AW'(0);
    mem_data_to_write = mem_write ? sel_wdata : DW'(0);
  end

  // Remember who issued last cycle's read so the RAM output can be steered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_rd <= 1'b0;
      pend_id <= mem_pkg::REQ_CPU;
    end else begin
      pend_rd <= mem_read;
      pend_id <= winner;
    end
  end

  assign rvalid0 = pend_rd & (pend_id == mem_pkg::REQ_CPU);
  assign rvalid1 = pend_rd & (pend_id == mem_pkg::REQ_DBG);
  assign rdata0  = rvalid0 ? mem_data_read : DW'(0);
  assign rdata1  = rvalid1 ? mem_data_read : DW'(0);

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a behavioural RAM and a
// scoreboard of expected read returns.
module tb_mem_arbiter;

  localparam int unsigned DW = 4;
  localparam int unsigned AW = 5;

  logic          clk;
  logic          rst_n;
  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata0, rdata1;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_read_address, mem_write_address;
  logic [DW-1:0] mem_data_to_write, mem_data_read;

  mem_arbiter #(.DW(DW), .AW(AW)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .req0              (req0),
    .we0               (we0),
    .addr0             (addr0),
    .wdata0            (wdata0),
    .req1              (req1),
    .we1               (we1),
    .addr1             (addr1),
    .wdata1            (wdata1),
    .gnt0              (gnt0),
    .gnt1              (gnt1),
    .rvalid0           (rvalid0),
    .rvalid1           (rvalid1),
    .rdata0            (rdata0),
    .rdata1            (rdata1),
    .mem_read          (mem_read),
    .mem_write         (mem_write),
    .mem_read_address  (mem_read_address),
    .mem_write_address (mem_write_address),
    .mem_data_to_write (mem_data_to_write),
    .mem_data_read     (mem_data_read)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural synchronous RAM: write commits at the edge, registered read.
  logic [DW-1:0] ram [32];
  logic [DW-1:0] ram_q;
  always @(posedge clk) begin
    if (mem_write) ram[mem_write_address] <= mem_data_to_write;
    if (mem_read)  ram_q <= ram[mem_read_address];
  end
  assign mem_data_read = ram_q;

  typedef struct {
    bit            id;
    logic [DW-1:0] data;
  } rsp_t;

  rsp_t          exp_q[$];
  logic [DW-1:0] shadow [32];
  bit            m_prio;
  int            gcnt [2];
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive a command pair, check the issue side against the
  // model, optionally pull reset before the edge, then check the return side.
  task automatic step(input bit r0, input bit w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                      input bit r1, input bit w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                      input bit kill);
    bit            e0, e1, ew;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    rsp_t          r;
    @(negedge clk);
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    #1;
    e0 = r0 && (!r1 || !m_prio);
    e1 = r1 && (!r0 || m_prio);
    chk("gnt0", 32'(gnt0), 32'(e0));
    chk("gnt1", 32'(gnt1), 32'(e1));
    if (e0 || e1) begin
      ew = e1 ? w1 : w0;
      ea = e1 ? a1 : a0;
      ed = e1 ? d1 : d0;
      chk("mem_write", 32'(mem_write), 32'(ew));
      chk("mem_read", 32'(mem_read), 32'(!ew));
      if (ew) begin
        chk("mem_write_address", 32'(mem_write_address), 32'(ea));
        chk("mem_data_to_write", 32'(mem_data_to_write), 32'(ed));
        shadow[ea] = ed;
      end else begin
        chk("mem_read_address", 32'(mem_read_address), 32'(ea));
        r.id = e1;
        r.data = shadow[ea];
        exp_q.push_back(r);
      end
      m_prio = !e1;
      gcnt[e1 ? 1 : 0]++;
    end else begin
      chk("idle_mem_write", 32'(mem_write), 32'(0));
      chk("idle_mem_read", 32'(mem_read), 32'(0));
      chk("idle_raddr", 32'(mem_read_address), 32'(0));
      chk("idle_waddr", 32'(mem_write_address), 32'(0));
      chk("idle_wdata", 32'(mem_data_to_write), 32'(0));
    end
    if (kill) begin
      #3 rst_n = 1'b0;
      exp_q.delete();
      m_prio = 1'b0;
    end
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      r = exp_q.pop_front();
      chk("rvalid0", 32'(rvalid0), 32'(!r.id));
      chk("rvalid1", 32'(rvalid1), 32'(r.id));
      chk(r.id ? "rdata1" : "rdata0", 32'(r.id ? rdata1 : rdata0), 32'(r.data));
      chk(r.id ? "rdata0_idle" : "rdata1_idle", 32'(r.id ? rdata0 : rdata1), 32'(0));
    end else begin
      chk("rvalid0_none", 32'(rvalid0), 32'(0));
      chk("rvalid1_none", 32'(rvalid1), 32'(0));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) begin
      ram[i] = '0;
      shadow[i] = '0;
    end
    ram_q = '0;
    m_prio = 1'b0;
    gcnt[0] = 0;
    gcnt[1] = 0;

    // Reset with both requesters active: nothing may be granted or issued.
    rst_n = 1'b0;
    req0 = 1'b1; we0 = 1'b1; addr0 = 5'd3; wdata0 = 4'h7;
    req1 = 1'b1; we1 = 1'b0; addr1 = 5'd4; wdata1 = 4'h0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_gnt0", 32'(gnt0), 32'(0));
    chk("rst_gnt1", 32'(gnt1), 32'(0));
    chk("rst_mem_read", 32'(mem_read), 32'(0));
    chk("rst_mem_write", 32'(mem_write), 32'(0));
    chk("rst_rvalid0", 32'(rvalid0), 32'(0));
    chk("rst_rvalid1", 32'(rvalid1), 32'(0));
    req0 = 1'b0; req1 = 1'b0;
    rst_n = 1'b1;

    // Contention: four cycles of both requesting, grants alternate from 0.
    for (int i = 0; i < 4; i++) step(1, 0, 5'd0, 4'h0, 1, 0, 5'd1, 4'h0, 0);
    chk("contention_gnt0_count", 32'(gcnt[0]), 32'(2));
    chk("contention_gnt1_count", 32'(gcnt[1]), 32'(2));

    // Write then read-back of the same address on consecutive cycles.
    step(1, 1, 5'd5, 4'hA, 0, 0, 5'd0, 4'h0, 0);
    step(1, 0, 5'd5, 4'h0, 0, 0, 5'd0, 4'h0, 0);
    step(0, 0, 5'd0, 4'h0, 0, 0, 5'd0, 4'h0, 0);

    // Lone requester 1 wins every cycle regardless of the pointer.
    for (int i = 0; i < 3; i++) step(0, 0, 5'd0, 4'h0, 1, 0, 5'd5, 4'h0, 0);

    // Preload 0..3 = 1,2,3,4; requester 1 writes last so requester 0 is preferred.
    step(1, 1, 5'd0, 4'h1, 0, 0, 5'd0, 4'h0, 0);
    step(1, 1, 5'd1, 4'h2, 0, 0, 5'd0, 4'h0, 0);
    step(1, 1, 5'd2, 4'h3, 0, 0, 5'd0, 4'h0, 0);
    step(0, 0, 5'd0, 4'h0, 1, 1, 5'd3, 4'h4, 0);

    // Interleaved back-to-back reads; each requester holds until granted.
    step(1, 0, 5'd0, 4'h0, 1, 0, 5'd2, 4'h0, 0);
    step(1, 0, 5'd1, 4'h0, 1, 0, 5'd2, 4'h0, 0);
    step(1, 0, 5'd1, 4'h0, 1, 0, 5'd3, 4'h0, 0);
    step(0, 0, 5'd0, 4'h0, 1, 0, 5'd3, 4'h0, 0);
    step(0, 0, 5'd0, 4'h0, 0, 0, 5'd0, 4'h0, 0);

    // Reset between a read grant and its return: no rvalid, pointer back to 0.
    step(1, 0, 5'd2, 4'h0, 0, 0, 5'd0, 4'h0, 0);
    step(1, 0, 5'd1, 4'h0, 0, 0, 5'd0, 4'h0, 1);
    @(negedge clk);
    req0 = 1'b0; req1 = 1'b0;
    rst_n = 1'b1;
    step(1, 0, 5'd0, 4'h0, 1, 0, 5'd3, 4'h0, 0);
    step(0, 0, 5'd0, 4'h0, 0, 0, 5'd0, 4'h0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_mem_arbiter
